apb_master_ms: RTL
==================

# apb_master_ms

Parametrised APB4 master bridge with multi-slave select, address decode and wait-state timeout. Converts the request side (valid/ready, rd0/wr1, address, write data, strobe) into APB SETUP/ACCESS transfers on one of NUM_SLAVES slaves. Returns read data and a 2-bit response code for every accepted request. Sits between the system-side request arbiter and the APB slave fabric, and replaces the single-slave bridge.

## Interface
- DATA_WIDTH, 32, data bus width (multiple of 8)
- ADDR_WIDTH, 32, address width
- NUM_SLAVES, 4, number of APB slaves (1..16)
- SEL_LSB, 12, lowest address bit of the slave-index field; field width SEL_W = max(1, $clog2(NUM_SLAVES))
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready; 0 disables the timeout
- i_clk_apb  in  1  clock; all logic on rising edge
- i_rst_apb  in  1  reset, synchronous, active-high
- i_valid  in  1  request valid
- i_rd0_wr1  in  1  0 = read, 1 = write
- i_addr  in  ADDR_WIDTH  request address
- i_wr_data  in  DATA_WIDTH  write data
- i_wr_strb  in  DATA_WIDTH/8  write byte strobes; ignored for reads
- o_ready  out  1  request accepted when i_valid & o_ready
- o_rd_valid  out  1  one-cycle pulse: read response
- o_wr_done  out  1  one-cycle pulse: write response
- o_rd_data  out  DATA_WIDTH  read data, valid with o_rd_valid
- o_resp  out  2  00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT; valid with either pulse
- o_psel  out  NUM_SLAVES  one-hot slave select
- o_penable, o_pwrite  out  1 each  APB control
- o_paddr  out  ADDR_WIDTH; o_pwdata  out  DATA_WIDTH; o_pstrb  out  DATA_WIDTH/8 (0 for reads)
- i_prdata  in  NUM_SLAVES*DATA_WIDTH  slave k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_pready, i_pslverr  in  NUM_SLAVES each  per-slave APB status

## Operation
- States: IDLE, SETUP, ACCESS, DERR.
- IDLE: o_ready=1. On accept, register address, data, strobe, direction and index = i_addr[SEL_LSB +: SEL_W]. Go to SETUP if index < NUM_SLAVES, otherwise DERR.
- SETUP: o_psel[index]=1, o_penable=0, APB address/data/control driven from the captured registers. Always goes to ACCESS.
- ACCESS: o_psel[index]=1 and o_penable=1; only i_pready[index] and i_pslverr[index] are sampled.
  - On pready=1: go to IDLE. Response is OK, or SLVERR if pslverr=1.
  - On TIMEOUT_CYCLES consecutive ACCESS cycles with pready=0: drop psel/penable and go to IDLE with response TIMEOUT.
- DERR: no APB activity for one cycle. Go to IDLE with response DECERR.
- Response (registered) is issued in the first IDLE cycle after completion: o_rd_valid or o_wr_done pulses, and o_resp is set.
- o_rd_data: captured i_prdata[index] for read responses OK and SLVERR; zero for DECERR and TIMEOUT. It holds until the next read response.
- o_resp holds its value until the next response.
- Outputs hold their values between transfers; o_psel is 0 outside SETUP and ACCESS.

## Timing
- Reset value: every output 0, including o_ready. The state is IDLE, and o_ready rises on the first cycle after reset is released.
- Zero-wait transfer: accept at edge T, SETUP during T+1, ACCESS during T+2, response pulse and o_ready=1 during T+3. Back-to-back peak rate is one transfer per 3 cycles.
- Each wait state adds 1 cycle.
- Decode error: response 2 cycles after accept.
- Timeout counter: resets on SETUP entry and increments each ACCESS cycle with pready=0. Timeout fires when the count reaches TIMEOUT_CYCLES; if pready=1 in that same cycle, normal completion wins.
- A response pulse and a new accept may coincide in the same IDLE cycle.
- Reset asserted mid-transfer: at the next edge all state and outputs return to reset values. The aborted request produces no response.

## Structure
- Package apb_master_ms_pkg: state enum (IDLE, SETUP, ACCESS, DERR), response enum (RESP_OK, RESP_SLVERR, RESP_DECERR, RESP_TIMEOUT).
- Sub-module apb_slave_decode: combinational index extraction, range check, one-hot select and prdata/pready/pslverr mux.
- Timeout counter width: max(1, $clog2(TIMEOUT_CYCLES+1)).

## Test plan
- Zero-wait write: addr 0x0000_1010 (slave 1), data 0xDEADBEEF, strb 0xF → o_psel=0010, SETUP then ACCESS, o_wr_done at T+3 with o_resp=00.
- Read with 3 wait states: slave 2 returns 0x1234_5678 → o_rd_valid at T+6, o_rd_data=0x12345678, o_resp=00.
- Read from slave 3 with pslverr=1 and prdata 0xA5A5A5A5 → o_resp=01, o_rd_data=0xA5A5A5A5.
- Decode error: NUM_SLAVES=3, addr 0x0000_3000 → no psel, o_rd_valid at T+2, o_resp=10, o_rd_data=0.
- Timeout: TIMEOUT_CYCLES=4, slave 0 never readies → psel drops after 4 ACCESS cycles, o_wr_done with o_resp=11. Next request is accepted in the same response cycle.
- Reset during ACCESS → next cycle all outputs 0, no response pulse; o_ready=1 one cycle after reset is released.

Source files
------------

// File: rtl/apb_master_ms_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_ms_pkg
//  Purpose  : Shared types for the multi-slave APB4 master bridge.
//             - state_e : transfer sequencer states
//             - resp_e  : 2-bit response code returned to the requester
//  Revision : 1.0  initial release
// ============================================================================
package apb_master_ms_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RESP_OK      = 2'b00,
    RESP_SLVERR  = 2'b01,
    RESP_DECERR  = 2'b10,
    RESP_TIMEOUT = 2'b11
  } resp_e;

  // Width of an index/counter field that must hold at least one bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_decode.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_decode
//  Purpose  : Combinational slave decode for apb_master_ms.
//             - Range check of the slave-index field of a new request.
//             - One-hot PSEL vector and prdata/pready/pslverr mux for the
//               index captured for the transfer in flight.
//  Ports    : i_sel_field  slave-index field of the incoming request address
//             i_idx        captured index of the transfer in flight
//             i_prdata/i_pready/i_pslverr  per-slave APB return buses
//             o_in_range   i_sel_field addresses an existing slave
//             o_sel        one-hot select for i_idx
//             o_prdata/o_pready/o_pslverr  return signals of slave i_idx
//  Revision : 1.0  initial release
// ============================================================================
module apb_slave_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]                 i_sel_field,
  input  logic [SEL_W-1:0]                 i_idx,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata,
  input  logic [NUM_SLAVES-1:0]            i_pready,
  input  logic [NUM_SLAVES-1:0]            i_pslverr,
  output logic                             o_in_range,
  output logic [NUM_SLAVES-1:0]            o_sel,
  output logic [DATA_WIDTH-1:0]            o_prdata,
  output logic                             o_pready,
  output logic                             o_pslverr
);

  // One extra bit so NUM_SLAVES itself is representable (e.g. 4 in a 2-bit field).
  localparam logic [SEL_W:0] NUM_SLAVES_W = (SEL_W+1)'(NUM_SLAVES);

  assign o_in_range = ({1'b0, i_sel_field} < NUM_SLAVES_W);

  always_comb begin
    o_sel     = '0;
    o_prdata  = '0;
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (i_idx == SEL_W'(k)) begin
        o_sel[k]  = 1'b1;
        o_prdata  = i_prdata[k*DATA_WIDTH +: DATA_WIDTH];
        o_pready  = i_pready[k];
        o_pslverr = i_pslverr[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_master_ms.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_ms
//  Purpose  : APB4 master bridge with multi-slave select, address decode and
//             wait-state timeout. One request (valid/ready) becomes one APB
//             SETUP/ACCESS transfer; every accepted request returns a
//             registered response pulse with a 2-bit code.
//  Ports    : i_clk_apb, i_rst_apb (sync, active-high)
//             request : i_valid, i_rd0_wr1, i_addr, i_wr_data, i_wr_strb, o_ready
//             response: o_rd_valid, o_wr_done, o_rd_data, o_resp
//             APB     : o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
//                       o_pstrb, i_prdata, i_pready, i_pslverr
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_ms
  import apb_master_ms_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             i_clk_apb,
  input  logic                             i_rst_apb,
  input  logic                             i_valid,
  input  logic                             i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [DATA_WIDTH/8-1:0]          i_wr_strb,
  output logic                             o_ready,
  output logic                             o_rd_valid,
  output logic                             o_wr_done,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic [1:0]                       o_resp,
  output logic [NUM_SLAVES-1:0]            o_psel,
  output logic                             o_penable,
  output logic                             o_pwrite,
  output logic [ADDR_WIDTH-1:0]            o_paddr,
  output logic [DATA_WIDTH-1:0]            o_pwdata,
  output logic [DATA_WIDTH/8-1:0]          o_pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata,
  input  logic [NUM_SLAVES-1:0]            i_pready,
  input  logic [NUM_SLAVES-1:0]            i_pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SEL_W  = clog2_min1(NUM_SLAVES);
  localparam int TO_W   = clog2_min1(TIMEOUT_CYCLES + 1);

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic                    write_q, write_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [TO_W-1:0]         cnt_q, cnt_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    wr_done_q, wr_done_d;
  logic [1:0]              resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                    req_in_range;
  logic [NUM_SLAVES-1:0]   sel_onehot;
  logic [DATA_WIDTH-1:0]   sel_prdata;
  logic                    sel_pready;
  logic                    sel_pslverr;
  logic                    accept;
  logic                    timeout_hit;
  logic                    done;

  apb_slave_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_W      (SEL_W)
  ) u_decode (
    .i_sel_field (i_addr[SEL_LSB +: SEL_W]),
    .i_idx       (idx_q),
    .i_prdata    (i_prdata),
    .i_pready    (i_pready),
    .i_pslverr   (i_pslverr),
    .o_in_range  (req_in_range),
    .o_sel       (sel_onehot),
    .o_prdata    (sel_prdata),
    .o_pready    (sel_pready),
    .o_pslverr   (sel_pslverr)
  );

  // o_ready is registered, so it is only ever high while the FSM sits in IDLE.
  assign accept = i_valid & ready_q;

  // Fires on the ACCESS cycle in which the count would reach TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    write_d    = write_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    rd_data_d  = rd_data_q;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = i_addr;
          wdata_d = i_wr_data;
          strb_d  = i_rd0_wr1 ? i_wr_strb : '0;
          write_d = i_rd0_wr1;
          idx_d   = i_addr[SEL_LSB +: SEL_W];
          state_d = req_in_range ? SETUP : DERR;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // A ready slave takes priority over a timeout in the same cycle.
        if (sel_pready) begin
          done    = 1'b1;
          state_d = IDLE;
          resp_d  = sel_pslverr ? RESP_SLVERR : RESP_OK;
          if (!write_q) rd_data_d = sel_prdata;
        end else if (timeout_hit) begin
          done    = 1'b1;
          state_d = IDLE;
          resp_d  = RESP_TIMEOUT;
          if (!write_q) rd_data_d = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      DERR: begin
        done    = 1'b1;
        state_d = IDLE;
        resp_d  = RESP_DECERR;
        if (!write_q) rd_data_d = '0;
      end
      default: state_d = IDLE;
    endcase

    rd_valid_d = done & ~write_q;
    wr_done_d  = done &  write_q;
    ready_d    = (state_d == IDLE);
  end

  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      resp_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      resp_q     <= resp_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_rd_valid = rd_valid_q;
  assign o_wr_done  = wr_done_q;
  assign o_rd_data  = rd_data_q;
  assign o_resp     = resp_q;
  assign o_psel     = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_onehot : '0;
  assign o_penable  = (state_q == ACCESS);
  assign o_pwrite   = write_q;
  assign o_paddr    = addr_q;
  assign o_pwdata   = wdata_q;
  assign o_pstrb    = strb_q;

endmodule
`default_nettype wire
